// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one serial multiplier engine between NREQ clients.
// Zero operands bypass the engine; a watchdog aborts jobs the engine never finishes.
module mul_share_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]      rsp_result,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    mul_start,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  input  logic                    mul_done,
  input  logic [2*WIDTH-1:0]      mul_result
);

  localparam int unsigned GW = $clog2(NREQ);
  localparam int unsigned WW = $clog2(TIMEOUT);
  localparam logic [GW-1:0] G_LAST  = GW'(NREQ - 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state;
  state_t              state_nx;
  logic [GW-1:0]       last_q;
  logic [GW-1:0]       grant_q;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic [WW-1:0]       wd;
  logic [2*WIDTH-1:0]  res_q;
  logic                err_q;

  logic                any_req;
  logic [GW-1:0]       gsel;
  logic [GW-1:0]       cand;
  logic [WIDTH-1:0]    sel_a;
  logic [WIDTH-1:0]    sel_b;
  logic                zero_op;
  logic                wd_expired;

  // Search starts just past the previous winner and wraps, so the last
  // served requester has the lowest priority next time.
  always_comb begin
    any_req = 1'b0;
    gsel    = '0;
    cand    = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = GW'((32'(last_q) + off) % NREQ);
      if (!any_req && req_valid[cand]) begin
        any_req = 1'b1;
        gsel    = cand;
      end
    end
  end

  assign sel_a      = req_a[gsel*WIDTH +: WIDTH];
  assign sel_b      = req_b[gsel*WIDTH +: WIDTH];
  assign zero_op    = (sel_a == '0) || (sel_b == '0);
  assign wd_expired = (wd == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_err    = 1'b0;
    mul_start  = 1'b0;
    mul_a      = '0;
    mul_b      = '0;
    busy       = (state != IDLE);
    rsp_result = res_q;
    case (state)
      IDLE: begin
        if (any_req) begin
          req_ready = NREQ'(1) << gsel;
          state_nx  = zero_op ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mul_start = 1'b1;
        mul_a     = op_a;
        mul_b     = op_b;
        state_nx  = WAIT;
      end
      WAIT: begin
        mul_a = op_a;
        mul_b = op_b;
        if (mul_done || wd_expired) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        rsp_valid = NREQ'(1) << grant_q;
        rsp_err   = err_q;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result/err are written on the edge entering RESP and then left alone,
  // which keeps rsp_result stable until the following response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= G_LAST;
      grant_q <= '0;
      op_a    <= '0;
      op_b    <= '0;
      wd      <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_q <= gsel;
            op_a    <= sel_a;
            op_b    <= sel_b;
            if (zero_op) begin
              res_q <= '0;
              err_q <= 1'b0;
            end
          end
        end
        ISSUE: begin
          wd <= '0;
        end
        WAIT: begin
          if (mul_done) begin
            res_q <= mul_result;
            err_q <= 1'b0;
          end else begin
            wd <= wd + WW'(1);
            if (wd_expired) begin
              res_q <= '0;
              err_q <= 1'b1;
            end
          end
        end
        RESP: begin
          last_q <= grant_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: the bench itself plays the multiplier
// engine and checks grants, products, zero bypass, watchdog and reset.
module tb_mul_share_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned WIDTH   = 16;
  localparam int unsigned TIMEOUT = 40;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]    rsp_result;
  logic                  rsp_err;
  logic                  busy;
  logic                  mul_start;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic                  mul_done;
  logic [2*WIDTH-1:0]    mul_result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_share_arbiter #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_result (mul_result)
  );

  task automatic clear_inputs();
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    mul_done   = 1'b0;
    mul_result = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at the negedge of the ISSUE cycle; pulses mul_done lat cycles later
  // and returns at the negedge of the cycle after the pulse.
  task automatic run_engine(input int unsigned lat, input logic [31:0] prod);
    repeat (lat) @(negedge clk);
    mul_done   = 1'b1;
    mul_result = prod;
    @(negedge clk);
    mul_done   = 1'b0;
    mul_result = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL reset_rsp_result got=%h exp=0", rsp_result); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start got=%b exp=0", mul_start); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    req_a[0 +: WIDTH] = 16'd3;
    req_b[0 +: WIDTH] = 16'd5;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL single_start got=%b exp=1", mul_start); end
    checks++; if (mul_a !== 16'd3) begin errors++; $display("FAIL single_mul_a got=%h exp=3", mul_a); end
    checks++; if (mul_b !== 16'd5) begin errors++; $display("FAIL single_mul_b got=%h exp=5", mul_b); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    run_engine(1, 32'd15);
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid); end
    checks++; if (rsp_result !== 32'd15) begin errors++; $display("FAIL single_result got=%h exp=f", rsp_result); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", rsp_err); end
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_drop got=%b exp=0000", rsp_valid); end
    checks++; if (rsp_result !== 32'd15) begin errors++; $display("FAIL single_result_hold got=%h exp=f", rsp_result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", busy); end
  endtask

  task automatic test_fairness();
    logic [15:0] fa [4] = '{16'd3, 16'hFFFF, 16'h1234, 16'd100};
    logic [15:0] fb [4] = '{16'd5, 16'hFFFF, 16'h0010, 16'd200};
    logic [31:0] fp [4] = '{32'd15, 32'hFFFE0001, 32'h00012340, 32'd20000};
    logic [3:0]  oh;
    int unsigned g;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i*WIDTH +: WIDTH] = fa[i];
      req_b[i*WIDTH +: WIDTH] = fb[i];
    end
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      g  = i % 4;
      oh = 4'b0001 << g;
      #1;
      checks++; if (req_ready !== oh) begin errors++; $display("FAIL fair_ready[%0d] got=%b exp=%b", i, req_ready, oh); end
      @(negedge clk);
      checks++; if (mul_a !== fa[g] || mul_b !== fb[g]) begin errors++; $display("FAIL fair_ops[%0d] got=%h,%h exp=%h,%h", i, mul_a, mul_b, fa[g], fb[g]); end
      run_engine(2, fp[g]);
      checks++; if (rsp_valid !== oh) begin errors++; $display("FAIL fair_rsp_valid[%0d] got=%b exp=%b", i, rsp_valid, oh); end
      checks++; if (rsp_result !== fp[g]) begin errors++; $display("FAIL fair_result[%0d] got=%h exp=%h", i, rsp_result, fp[g]); end
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    req_valid = 4'b0100;
    req_a[2*WIDTH +: WIDTH] = 16'h0000;
    req_b[2*WIDTH +: WIDTH] = 16'h1234;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL zero_ready got=%b exp=0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL zero_rsp_valid got=%b exp=0100", rsp_valid); end
    checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL zero_result got=%h exp=0", rsp_result); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL zero_err got=%b exp=0", rsp_err); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL zero_no_start got=%b exp=0", mul_start); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL zero_idle got=%b/%b exp=0/0000", busy, rsp_valid); end
  endtask

  task automatic test_timeout();
    int unsigned n;
    req_valid = 4'b1000;
    req_a[3*WIDTH +: WIDTH] = 16'd7;
    req_b[3*WIDTH +: WIDTH] = 16'd9;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL to_ready got=%b exp=1000", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL to_start got=%b exp=1", mul_start); end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid == 4'b0000 && n < 60);
    checks++; if (n !== TIMEOUT + 1) begin errors++; $display("FAIL to_cycles got=%0d exp=%0d", n, TIMEOUT + 1); end
    checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL to_rsp_valid got=%b exp=1000", rsp_valid); end
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", rsp_err); end
    checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL to_result got=%h exp=0", rsp_result); end
    @(negedge clk);
    req_valid = 4'b0001;
    req_a[0 +: WIDTH] = 16'd6;
    req_b[0 +: WIDTH] = 16'd7;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL to_next_ready got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    run_engine(3, 32'd42);
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL to_next_rsp got=%b exp=0001", rsp_valid); end
    checks++; if (rsp_result !== 32'd42 || rsp_err !== 1'b0) begin errors++; $display("FAIL to_next_result got=%h/%b exp=2a/0", rsp_result, rsp_err); end
    @(negedge clk);
  endtask

  task automatic test_race();
    req_valid = 4'b0010;
    req_a[1*WIDTH +: WIDTH] = 16'h0100;
    req_b[1*WIDTH +: WIDTH] = 16'h0100;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL race_ready got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    // mul_done lands in the last WAIT cycle, the one where the watchdog expires
    run_engine(TIMEOUT, 32'h00010000);
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL race_rsp_valid got=%b exp=0010", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL race_err got=%b exp=0", rsp_err); end
    checks++; if (rsp_result !== 32'h00010000) begin errors++; $display("FAIL race_result got=%h exp=00010000", rsp_result); end
    @(negedge clk);
    mul_done   = 1'b1;
    mul_result = 32'h0000DEAD;
    @(negedge clk);
    mul_done   = 1'b0;
    mul_result = '0;
    checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL spurious_done got=%b/%b exp=0000/0", rsp_valid, busy); end
    checks++; if (rsp_result !== 32'h00010000) begin errors++; $display("FAIL spurious_hold got=%h exp=00010000", rsp_result); end
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL spurious_late got=%b exp=0000", rsp_valid); end
  endtask

  task automatic test_reset_midop();
    req_valid = 4'b0100;
    req_a[2*WIDTH +: WIDTH] = 16'd5;
    req_b[2*WIDTH +: WIDTH] = 16'd5;
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || mul_start !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ctl got=%b%b%b exp=000000", busy, mul_start, req_ready); end
    checks++; if (mul_a !== 16'h0 || mul_b !== 16'h0) begin errors++; $display("FAIL rst_mul_ops got=%h,%h exp=0,0", mul_a, mul_b); end
    checks++; if (rsp_valid !== 4'b0000 || rsp_err !== 1'b0 || rsp_result !== 32'h0) begin errors++; $display("FAIL rst_rsp got=%b/%b/%h exp=0000/0/0", rsp_valid, rsp_err, rsp_result); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_no_rsp[%0d] got=%b exp=0000", i, rsp_valid); end
    end
    req_a     = '0;
    req_b     = '0;
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant got=%b exp=0001", req_ready); end
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL rst_first_rsp got=%b exp=0001", rsp_valid); end
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rst_second_grant got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL rst_second_rsp got=%b exp=0010", rsp_valid); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_zero();
    test_timeout();
    test_race();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "bench timeout");
  end

endmodule
